shift_left_pipe: RTL and testbench

//  Pipelined left shifter/rotator: companion to the combinational arithmetic right shifter.

---
 rtl/shift_left_pipe.sv | 133 +++++++++++++
 tb/tb_shift_left_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_left_pipe.sv
// Four-stage pipelined left shifter/rotator (SLL, ROL, SLA) with valid/ready flow control.
// Stage k applies a shift of 2^k when count bit k is set; SLA raises a sticky signed-overflow flag.
module shift_left_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [CNT_W-1:0] in_cnt_i,
    input  logic [1:0]       in_op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_ovf_o
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.

    localparam int          STAGES = CNT_W;
    localparam logic [1:0]  OP_ROL = 2'b01;
    localparam logic [1:0]  OP_SLA = 2'b10;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] ovf_q, ovf_d;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_valid, src_ovf;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [WIDTH-1:0]  src_data [STAGES];
    logic [1:0]        op_q [STAGES];
    logic [1:0]        op_d [STAGES];
    logic [1:0]        src_op [STAGES];
    logic [CNT_W-1:0]  cnt_q [STAGES];
    logic [CNT_W-1:0]  cnt_d [STAGES];
    logic [CNT_W-1:0]  src_cnt [STAGES];

    function automatic logic [WIDTH-1:0] shl_by(input logic [WIDTH-1:0] d, input int sh);
        return d << sh;
    endfunction

    function automatic logic [WIDTH-1:0] rol_by(input logic [WIDTH-1:0] d, input int sh);
        return (d << sh) | (d >> (WIDTH - sh));
    endfunction

    // True when the top sh+1 bits are not all copies of the sign bit.
    function automatic logic top_differs(input logic [WIDTH-1:0] d, input int sh);
        logic [WIDTH-1:0] t;
        t = d ^ {WIDTH{d[WIDTH-1]}};
        return (t >> (WIDTH - 1 - sh)) != '0;
    endfunction

    // Ready chain from the output back to stage 0: a stage can load when it is
    // empty or everything downstream of it is moving.
    always_comb begin
        logic chain;
        chain = out_ready_i;
        rdy   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = ~valid_q[k] | chain;
            rdy[k] = chain;
        end
    end

    always_comb begin
        src_valid[0] = in_valid_i;
        src_data[0]  = in_data_i;
        src_op[0]    = in_op_i;
        src_cnt[0]   = in_cnt_i;
        src_ovf[0]   = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_op[k]    = op_q[k-1];
            src_cnt[k]   = cnt_q[k-1];
            src_ovf[k]   = ovf_q[k-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k] = src_data[k];
                    op_d[k]   = src_op[k];
                    cnt_d[k]  = src_cnt[k];
                    ovf_d[k]  = src_ovf[k];
                    if (src_cnt[k][k]) begin
                        if (src_op[k] == OP_ROL) begin
                            data_d[k] = rol_by(src_data[k], 1 << k);
                        end else begin
                            data_d[k] = shl_by(src_data[k], 1 << k);
                        end
                        if (src_op[k] == OP_SLA && top_differs(src_data[k], 1 << k)) begin
                            ovf_d[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ovf_q   <= '0;
            data_q  <= '{default: '0};
            op_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = valid_q[STAGES-1];
    assign out_data_o  = data_q[STAGES-1];
    assign out_ovf_o   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_shift_left_pipe.sv
// Bench for shift_left_pipe: directed literal cases, stall, async reset and random
// valid/ready traffic scored against a plain-arithmetic model of SLL/ROL/SLA.
module tb_shift_left_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready_o;
    logic [15:0] in_data = '0;
    logic [3:0]  in_cnt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid_o;
    logic        out_ready = 1'b1;
    logic [15:0] out_data_o;
    logic        out_ovf_o;

    logic [16:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          pops = 0;
    bit          rand_done = 1'b0;

    shift_left_pipe #(.WIDTH(16), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data),
        .in_cnt_i    (in_cnt),
        .in_op_i     (in_op),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_o),
        .out_ovf_o   (out_ovf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Result {ovf, data} from the operation's definition, not from stage structure.
    function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] c,
                                          input logic [1:0] op);
        logic [31:0]        t;
        logic [15:0]        r;
        logic signed [15:0] s;
        logic signed [15:0] sh;
        logic               o;
        t  = {d, d} << c;
        s  = d;
        sh = s <<< c;
        o  = 1'b0;
        if (op == 2'b01) r = t[31:16];
        else             r = d << c;
        if (op == 2'b10) o = ((sh >>> c) != s);
        return {o, r};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Scoreboard: record accepted ops, check every valid output against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check_eq("out_result", {out_ovf_o, out_data_o}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            if (in_valid && in_ready_o) exp_q.push_back(model(in_data, in_cnt, in_op));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
        int n;
        bit acc;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = c;
        in_op    = op;
        do begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0;
        check_eq("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic run_one(input string name, input logic [15:0] d, input logic [3:0] c,
                           input logic [1:0] op, input logic [15:0] exp_d, input logic exp_o);
        int lat;
        out_ready = 1'b1;
        check_eq({name, "_model"}, model(d, c, op), {exp_o, exp_d});
        send(d, c, op);
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({name, "_latency"}, lat, 4);
        check_eq({name, "_data"}, out_data_o, exp_d);
        check_eq({name, "_ovf"}, out_ovf_o, exp_o);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(name, exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        int stale;
        logic [15:0] d;

        // Reset state
        #2;
        check_eq("reset_out_valid", out_valid_o, 0);
        check_eq("reset_out_data", out_data_o, 0);
        check_eq("reset_out_ovf", out_ovf_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("reset_in_ready", in_ready_o, 1);

        // Directed literal cases
        run_one("sll_f1_4",    16'h00F1, 4'd4,  2'b00, 16'h0F10, 1'b0);
        run_one("rol_8001_1",  16'h8001, 4'd1,  2'b01, 16'h0003, 1'b0);
        run_one("rol_1234_8",  16'h1234, 4'd8,  2'b01, 16'h3412, 1'b0);
        run_one("rol_beef_0",  16'hBEEF, 4'd0,  2'b01, 16'hBEEF, 1'b0);
        run_one("sla_4000_1",  16'h4000, 4'd1,  2'b10, 16'h8000, 1'b1);
        run_one("sla_ffff_15", 16'hFFFF, 4'd15, 2'b10, 16'h8000, 1'b0);
        run_one("sla_0001_14", 16'h0001, 4'd14, 2'b10, 16'h4000, 1'b0);
        run_one("sla_0001_15", 16'h0001, 4'd15, 2'b10, 16'h8000, 1'b1);
        run_one("op3_c001_2",  16'hC001, 4'd2,  2'b11, 16'h0004, 1'b0);
        run_one("sll_8000_0",  16'h8000, 4'd0,  2'b00, 16'h8000, 1'b0);

        // Back-to-back 8 ops with a stall from cycle 2
        p0 = pops;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'h1111 * 16'(i + 1), 4'(i * 2 + 1), 2'(i % 3));
                end
            end
            begin
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                repeat (12) begin
                    @(posedge clk);
                    #1;
                end
                check_eq("stall_in_ready", in_ready_o, 0);
                check_eq("stall_out_valid", out_valid_o, 1);
                check_eq("stall_occupancy", exp_q.size(), 4);
                out_ready = 1'b1;
            end
        join
        wait_drain("stall_drain");
        check_eq("stall_count", pops - p0, 8);

        // Random traffic with valid gaps and ready toggling
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    case ($urandom_range(0, 5))
                        0:       d = 16'hFFFF;
                        1:       d = 16'h0001;
                        2:       d = 16'h8000;
                        3:       d = 16'h7FFF;
                        default: d = 16'($urandom);
                    endcase
                    send(d, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("random_drain");
        check_eq("random_count", pops - p0, 10000);

        // Async reset with 3 ops in flight while stalled
        out_ready = 1'b0;
        send(16'h00FF, 4'd3, 2'b00);
        send(16'h1234, 4'd5, 2'b01);
        send(16'h4001, 4'd1, 2'b10);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_reset_valid", out_valid_o, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("async_reset_valid", out_valid_o, 0);
        check_eq("async_reset_data", out_data_o, 0);
        check_eq("async_reset_ovf", out_ovf_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_one("post_reset", 16'h0003, 4'd2, 2'b00, 16'h000C, 1'b0);
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid_o) stale++;
        end
        check_eq("post_reset_stale", stale, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
